microop_sequencer: RTL

MICROOP_SEQUENCER -- requirements
Module: microop_sequencer

---
 rtl/microop_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/microop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : microop_sequencer
//  Description : Fetch/decode/execute sequencer that turns a byte-coded
//                program held in synchronous RAM into 16-bit micro-op words
//                for the control unit, with an operand buffer, a status
//                handshake on the settle phase and sticky illegal reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module microop_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  mem_dataout,
    input  logic [1:0]  status,
    output logic [15:0] control_signals,
    output logic [7:0]  ibuf,
    output logic        halted,
    output logic        illegal
);

    // Sequencer states; SETTLE may last several cycles, all others one.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_FWAIT   = 4'd1,
        S_DECODE  = 4'd2,
        S_OPFETCH = 4'd3,
        S_OPWAIT  = 4'd4,
        S_OPINC   = 4'd5,
        S_EXEC    = 4'd6,
        S_ACT     = 4'd7,
        S_SETTLE  = 4'd8,
        S_HALT    = 4'd9
    } state_t;

    // Instruction class, decoded once when the opcode byte arrives.
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDI  = 3'd1,
        OP_ALU  = 3'd2,
        OP_JMP  = 3'd3,
        OP_HALT = 3'd4,
        OP_ILL  = 3'd5
    } opclass_t;

    // Last settle cycle index before the handshake is declared lost.
    localparam logic [1:0] c_SETTLE_LAST  = 2'd3;
    // Status code that confirms the control unit consumed the action.
    localparam logic [1:0] c_STATUS_DONE  = 2'd1;
    // states field values carried in the top two bits of the word.
    localparam logic [1:0] c_STATES_IDLE  = 2'd0;
    localparam logic [1:0] c_STATES_XFER  = 2'd1;
    // Register-operand selector codes.
    localparam logic [1:0] c_ROP_NONE     = 2'd0;
    localparam logic [1:0] c_ROP_IBUF     = 2'd1;
    localparam logic [1:0] c_ROP_ALU      = 2'd2;

    state_t     r_state;
    state_t     w_next_state;
    opclass_t   r_class;
    opclass_t   w_fetch_class;
    logic [2:0] r_reg;
    logic [7:0] r_ibuf;
    logic [1:0] r_settle_cnt;
    logic [1:0] w_settle_cnt_next;
    logic       w_set_illegal;
    logic [15:0] r_ctrl;
    logic [15:0] w_next_word;
    logic       r_halted;
    logic       r_illegal;
    // Low after reset release until the first edge, so that the FETCH word
    // is presented for one full clock cycle before the machine advances.
    logic       r_run;

    // Assemble a micro-op word from its individual fields.
    function automatic logic [15:0] pack_word(
        input logic [1:0] states_f,
        input logic       ei,
        input logic       ea,
        input logic       csel,
        input logic       rd_en,
        input logic       ipopsel,
        input logic [1:0] ropsel,
        input logic [2:0] regsel,
        input logic [3:0] asel
    );
        return {states_f, ei, ea, csel, rd_en, ipopsel, ropsel, regsel, asel};
    endfunction

    // Classify the incoming program byte so only class and register are kept.
    always_comb begin
        w_fetch_class = OP_ILL;
        case (mem_dataout[7:4])
            4'h0:    w_fetch_class = OP_NOP;
            4'h1:    w_fetch_class = OP_LDI;
            4'h2:    w_fetch_class = OP_ALU;
            4'h4:    w_fetch_class = OP_JMP;
            4'hF:    w_fetch_class = OP_HALT;
            default: w_fetch_class = OP_ILL;
        endcase
    end

    // Next-state logic, settle-phase timeout counting and illegal detection.
    always_comb begin
        w_next_state      = r_state;
        w_settle_cnt_next = r_settle_cnt;
        w_set_illegal     = 1'b0;
        if (!r_run) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   w_next_state = S_FWAIT;
                S_FWAIT:   w_next_state = S_DECODE;
                S_DECODE: begin
                    case (r_class)
                        OP_NOP:  w_next_state = S_FETCH;
                        OP_LDI,
                        OP_ALU,
                        OP_JMP:  w_next_state = S_OPFETCH;
                        OP_HALT: w_next_state = S_HALT;
                        default: begin
                            w_next_state  = S_HALT;
                            w_set_illegal = 1'b1;
                        end
                    endcase
                end
                S_OPFETCH: w_next_state = S_OPWAIT;
                S_OPWAIT:  w_next_state = S_OPINC;
                S_OPINC:   w_next_state = S_EXEC;
                S_EXEC:    w_next_state = (r_class == OP_ALU) ? S_FETCH : S_ACT;
                S_ACT: begin
                    w_next_state      = S_SETTLE;
                    w_settle_cnt_next = 2'd0;
                end
                S_SETTLE: begin
                    if (status == c_STATUS_DONE) begin
                        w_next_state = S_FETCH;
                    end else if (r_settle_cnt == c_SETTLE_LAST) begin
                        w_next_state  = S_HALT;
                        w_set_illegal = 1'b1;
                    end else begin
                        w_settle_cnt_next = r_settle_cnt + 2'd1;
                    end
                end
                S_HALT:    w_next_state = S_HALT;
                default:   w_next_state = S_FETCH;
            endcase
        end
    end

    // Micro-op word for the state being entered; registered at the edge.
    always_comb begin
        w_next_word = 16'h0000;
        case (w_next_state)
            S_FETCH,
            S_OPFETCH: w_next_word = pack_word(c_STATES_IDLE, 1'b0, 1'b0, 1'b1, 1'b1,
                                               1'b0, c_ROP_NONE, 3'd0, 4'd0);
            S_DECODE,
            S_OPINC:   w_next_word = pack_word(c_STATES_IDLE, 1'b1, 1'b0, 1'b0, 1'b0,
                                               1'b0, c_ROP_NONE, 3'd0, 4'd0);
            S_EXEC: begin
                if (r_class == OP_ALU) begin
                    w_next_word = pack_word(c_STATES_IDLE, 1'b0, 1'b1, 1'b0, 1'b0,
                                            1'b0, c_ROP_ALU, r_reg, r_ibuf[3:0]);
                end else begin
                    w_next_word = pack_word(c_STATES_XFER, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, c_ROP_NONE, 3'd0, 4'd0);
                end
            end
            S_ACT: begin
                if (r_class == OP_LDI) begin
                    w_next_word = pack_word(c_STATES_IDLE, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, c_ROP_IBUF, r_reg, 4'd0);
                end else if (r_class == OP_JMP) begin
                    w_next_word = pack_word(c_STATES_IDLE, 1'b1, 1'b0, 1'b0, 1'b0,
                                            1'b1, c_ROP_NONE, 3'd0, 4'd0);
                end else begin
                    w_next_word = 16'h0000;
                end
            end
            default:   w_next_word = 16'h0000;
        endcase
    end

    // State, output word, operand buffer and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_run        <= 1'b0;
            r_class      <= OP_NOP;
            r_reg        <= 3'd0;
            r_ibuf       <= 8'h00;
            r_settle_cnt <= 2'd0;
            r_ctrl       <= 16'h0000;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_state      <= w_next_state;
            r_ctrl       <= w_next_word;
            r_settle_cnt <= w_settle_cnt_next;
            r_halted     <= (w_next_state == S_HALT);
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (r_state == S_FWAIT) begin
                r_class <= w_fetch_class;
                r_reg   <= mem_dataout[2:0];
            end
            if (r_state == S_OPWAIT) begin
                r_ibuf <= mem_dataout;
            end
        end
    end

    assign control_signals = r_ctrl;
    assign ibuf            = r_ibuf;
    assign halted          = r_halted;
    assign illegal         = r_illegal;

endmodule
`default_nettype wire
